// File: rtl/regex_instr_mem_responder.sv
// Instruction-fetch responder: serves one CPU fetch at a time from an internal program RAM,
// answering with a one-cycle memory_ready pulse READ_LATENCY cycles after acceptance.
module regex_instr_mem_responder #(
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int READ_LATENCY      = 2,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         memory_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
    output logic                         memory_ready,
    output logic [MEMORY_WIDTH-1:0]      memory_data,
    input  logic                         prog_write_en,
    input  logic [MEMORY_ADDR_WIDTH-1:0] prog_addr,
    input  logic [MEMORY_WIDTH-1:0]      prog_data,
    output logic [COUNT_WIDTH-1:0]       fetch_count,
    output logic                         busy
);

    localparam int       DEPTH    = 2 ** MEMORY_ADDR_WIDTH;
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);
    localparam bit       SINGLE   = (READ_LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND, S_COOLDOWN} state_t;

    logic [MEMORY_WIDTH-1:0] mem [DEPTH];

    state_t                  state_q;
    logic [3:0]              lat_q;
    logic [MEMORY_WIDTH-1:0] rd_q;
    logic                    ready_q;
    logic [MEMORY_WIDTH-1:0] data_q;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [COUNT_WIDTH-1:0]  count_d;

    // Program RAM has no reset; non-blocking write gives read-before-write on a same-edge fetch.
    always_ff @(posedge clk) begin
        if (prog_write_en) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (memory_valid) begin
                        rd_q <= mem[memory_addr];
                        if (SINGLE) begin
                            state_q <= S_RESPOND;
                            ready_q <= 1'b1;
                            data_q  <= mem[memory_addr];
                            count_q <= count_d;
                        end else begin
                            state_q <= S_WAIT;
                            lat_q   <= LAT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    lat_q <= lat_q - 1'b1;
                    if (lat_q == 4'd1) begin
                        state_q <= S_RESPOND;
                        ready_q <= 1'b1;
                        data_q  <= rd_q;
                        count_q <= count_d;
                    end
                end
                S_RESPOND: begin
                    ready_q <= 1'b0;
                    state_q <= S_COOLDOWN;
                end
                // The CPU is still holding the request it was just served.
                S_COOLDOWN: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign memory_ready = ready_q;
    assign memory_data  = data_q;
    assign fetch_count  = count_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_regex_instr_mem_responder.sv
// Directed bench for regex_instr_mem_responder: table of fetch vectors plus hand sequences
// for handshake, write collision, back-to-back sweep, reset abort and counter saturation.
module tb_regex_instr_mem_responder;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memory_valid = 1'b0;
    logic [10:0] memory_addr = '0;
    logic        prog_write_en = 1'b0;
    logic [10:0] prog_addr = '0;
    logic [19:0] prog_data = '0;

    logic        memory_ready;
    logic [19:0] memory_data;
    logic [15:0] fetch_count;
    logic        busy;

    logic        sat_ready;
    logic [19:0] sat_data;
    logic [3:0]  sat_count;
    logic        sat_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regex_instr_mem_responder #(
        .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .READ_LATENCY(L), .COUNT_WIDTH(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .memory_valid(memory_valid), .memory_addr(memory_addr),
        .memory_ready(memory_ready), .memory_data(memory_data),
        .prog_write_en(prog_write_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_count(fetch_count), .busy(busy)
    );

    regex_instr_mem_responder #(
        .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .READ_LATENCY(L), .COUNT_WIDTH(4)
    ) u_sat (
        .clk(clk), .rst(rst),
        .memory_valid(memory_valid), .memory_addr(memory_addr),
        .memory_ready(sat_ready), .memory_data(sat_data),
        .prog_write_en(prog_write_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_count(sat_count), .busy(sat_busy)
    );

    typedef struct {
        logic [10:0] addr;
        logic [19:0] word;
        logic [19:0] exp_data;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic load(input logic [10:0] a, input logic [19:0] d);
        prog_write_en = 1'b1;
        prog_addr     = a;
        prog_data     = d;
        @(negedge clk);
        prog_write_en = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input logic [19:0] exp, output int rcyc);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (memory_ready === 1'b1) seen = 1;
        end
        rcyc = cyc;
        chk({nm, " latency"}, n, L);
        chk({nm, " data"}, memory_data, exp);
    endtask

    task automatic fetch(input logic [10:0] a, input logic [19:0] exp, input string nm,
                         output int rcyc);
        memory_valid = 1'b1;
        memory_addr  = a;
        wait_ready(nm, exp, rcyc);
        @(negedge clk);
        chk({nm, " ready one cycle"}, memory_ready, 0);
        memory_valid = 1'b0;
        @(negedge clk);
        chk({nm, " idle after"}, busy, 0);
    endtask

    function automatic logic [19:0] sweep_word(input int i);
        return 20'h50000 + 20'(i * 20'h111);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int prev;
        int pulses;

        vt[0] = '{addr: 11'h000, word: 20'hFFFFF, exp_data: 20'hFFFFF};
        vt[1] = '{addr: 11'h7FF, word: 20'h0ABCD, exp_data: 20'h0ABCD};
        vt[2] = '{addr: 11'h001, word: 20'h12345, exp_data: 20'h12345};
        vt[3] = '{addr: 11'h7FE, word: 20'h00000, exp_data: 20'h00000};
        vt[4] = '{addr: 11'h3C3, word: 20'hA5A5A, exp_data: 20'hA5A5A};
        vt[5] = '{addr: 11'h0AB, word: 20'h7E001, exp_data: 20'h7E001};

        repeat (2) @(negedge clk);
        chk("reset ready", memory_ready, 0);
        chk("reset data", memory_data, 0);
        chk("reset count", fetch_count, 0);
        chk("reset busy", busy, 0);

        load(11'h0AA, 20'h041AA);
        load(11'h100, 20'h11111);
        for (int i = 0; i < 6; i++) load(vt[i].addr, vt[i].word);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch, then data must hold with the request dropped.
        fetch(11'h0AA, 20'h041AA, "single", rc);
        chk("single count", fetch_count, 1);
        repeat (5) @(negedge clk);
        chk("single data held", memory_data, 20'h041AA);

        for (int i = 0; i < 6; i++) begin
            fetch(vt[i].addr, vt[i].exp_data, $sformatf("vec%0d", i), rc);
        end
        chk("table count", fetch_count, 7);

        // CPU keeps valid high through COOLDOWN: no second acceptance.
        memory_valid = 1'b1;
        memory_addr  = 11'h0AA;
        wait_ready("handshake", 20'h041AA, rc);
        @(negedge clk);
        chk("handshake cooldown pulse", memory_ready, 0);
        @(negedge clk);
        chk("handshake busy", busy, 0);
        memory_valid = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (memory_ready === 1'b1) pulses++;
        end
        chk("handshake quiet pulses", pulses, 0);
        chk("handshake quiet busy", busy, 0);
        chk("handshake count", fetch_count, 8);

        // Same-address write on the acceptance edge: old word returned.
        memory_valid  = 1'b1;
        memory_addr   = 11'h100;
        prog_write_en = 1'b1;
        prog_addr     = 11'h100;
        prog_data     = 20'h22222;
        @(negedge clk);
        prog_write_en = 1'b0;
        chk("collision busy", busy, 1);
        pulses = 0;
        while (memory_ready !== 1'b1 && pulses < 20) begin
            @(negedge clk);
            pulses++;
        end
        chk("collision latency", pulses + 1, L);
        chk("collision old word", memory_data, 20'h11111);
        @(negedge clk);
        memory_valid = 1'b0;
        @(negedge clk);
        fetch(11'h100, 20'h22222, "collision repeat", rc);

        // Back-to-back sweep from a clean count.
        for (int i = 170; i <= 313; i++) load(11'(i), sweep_word(i));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        prev = -1;
        for (int i = 170; i <= 313; i++) begin
            fetch(11'(i), sweep_word(i), $sformatf("sweep%0d", i), rc);
            if (prev >= 0) chk($sformatf("sweep%0d spacing", i), rc - prev, L + 2);
            prev = rc;
        end
        chk("sweep count", fetch_count, 144);
        chk("sweep sat count", sat_count, 15);

        // Reset asserted while waiting aborts the response.
        memory_valid = 1'b1;
        memory_addr  = 11'h7FF;
        @(negedge clk);
        chk("abort in wait", busy, 1);
        rst = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (memory_ready === 1'b1) pulses++;
        end
        chk("abort pulses", pulses, 0);
        chk("abort data", memory_data, 0);
        chk("abort count", fetch_count, 0);
        rst = 1'b1;
        wait_ready("abort refetch", 20'h0ABCD, rc);
        @(negedge clk);
        memory_valid = 1'b0;
        @(negedge clk);
        chk("abort refetch count", fetch_count, 1);

        // Saturation of the 4-bit counter.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fetch(11'(170 + i), sweep_word(170 + i), $sformatf("sat%0d", i), rc);
            if (i == 13) chk("sat count 14", sat_count, 14);
            if (i == 14) chk("sat count 15", sat_count, 15);
        end
        chk("sat count final", sat_count, 15);
        chk("sat main count", fetch_count, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
